// File: rtl/mmio_gpo_pulse.sv
// MMIO general-purpose output slot with atomic set/clear/toggle writes and a
// hardware one-shot pulse generator that ORs a timed mask onto the outputs.
module mmio_gpo_pulse #(
  parameter int unsigned  W       = 32,
  parameter int unsigned  CNT_W   = 24,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cs,
  input  logic          write,
  input  logic          read,
  input  logic [4:0]    addr,
  input  logic [31:0]   write_data,
  output logic [31:0]   read_data,
  output logic [W-1:0]  dout
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [W-1:0]     W_ZERO   = {W{1'b0}};

  logic [W-1:0]     data_q, data_d;
  logic [W-1:0]     pmask_q, pmask_d;
  logic [W-1:0]     dout_q;
  logic [CNT_W-1:0] plen_q, plen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     wd_s;
  logic             wr_s;
  logic             busy_s;
  logic             pulse_go_s;
  logic             unused_bus_s;

  assign wr_s         = cs & write;
  assign wd_s         = write_data[W-1:0];
  assign busy_s       = (cnt_q != CNT_ZERO);
  assign pulse_go_s   = wr_s && (addr == 5'd5) && (plen_q != CNT_ZERO) && (wd_s != W_ZERO);
  // The read strobe has no side effects; the slot decodes purely on addr.
  assign unused_bus_s = read;

  // Static data and pulse-length register updates from bus writes.
  always_comb begin
    data_d = data_q;
    plen_d = plen_q;
    if (wr_s) begin
      case (addr)
        5'd0:    data_d = wd_s;
        5'd1:    data_d = data_q | wd_s;
        5'd2:    data_d = data_q & ~wd_s;
        5'd3:    data_d = data_q ^ wd_s;
        5'd4:    plen_d = write_data[CNT_W-1:0];
        default: begin
          data_d = data_q;
          plen_d = plen_q;
        end
      endcase
    end else begin
      data_d = data_q;
      plen_d = plen_q;
    end
  end

  // Pulse generator: a new PULSE write wins over expiry so pulsing bits never glitch low.
  always_comb begin
    pmask_d = pmask_q;
    cnt_d   = cnt_q;
    if (pulse_go_s) begin
      pmask_d = pmask_q | wd_s;
      cnt_d   = plen_q;
    end else if (cnt_q == CNT_ONE) begin
      pmask_d = W_ZERO;
      cnt_d   = CNT_ZERO;
    end else if (busy_s) begin
      cnt_d   = cnt_q - CNT_ONE;
    end else begin
      pmask_d = pmask_q;
      cnt_d   = cnt_q;
    end
  end

  // State registers; dout is registered from next-state so writes show after one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= RST_VAL;
      plen_q  <= CNT_ZERO;
      pmask_q <= W_ZERO;
      cnt_q   <= CNT_ZERO;
      dout_q  <= RST_VAL;
    end else begin
      data_q  <= data_d;
      plen_q  <= plen_d;
      pmask_q <= pmask_d;
      cnt_q   <= cnt_d;
      dout_q  <= data_d | pmask_d;
    end
  end

  assign dout = dout_q;

  // Readback mux; unused upper bits stay zero.
  always_comb begin
    read_data = 32'h0000_0000;
    case (addr)
      5'd0:    read_data[W-1:0]     = data_q;
      5'd4:    read_data[CNT_W-1:0] = plen_q;
      5'd5:    read_data[W-1:0]     = pmask_q;
      5'd6:    read_data[0]         = busy_s;
      default: read_data            = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_mmio_gpo_pulse.sv
// Bench for mmio_gpo_pulse: a vector table, hand-written pulse sequences and a
// randomized run against a timeline-based reference model.
module tb_mmio_gpo_pulse;

  localparam logic [31:0] RSTV = 32'h0000_00A5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs, write, read;
  logic [4:0]  addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [31:0] dout;

  int n_cmp = 0;
  int n_err = 0;

  mmio_gpo_pulse #(.W(32), .CNT_W(24), .RST_VAL(RSTV)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .write(write), .read(read),
    .addr(addr), .write_data(write_data), .read_data(read_data), .dout(dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] exp_dout;
    logic [4:0]  ra;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  // Reference model: pulse lifetime kept as an absolute edge number.
  logic [31:0] m_data, m_mask;
  logic [23:0] m_plen;
  int          m_t, m_exp;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; write_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input int idx, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, idx, read_data, exp);
  endtask

  function automatic logic m_active();
    return m_t < m_exp;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd0:    return m_data;
      5'd4:    return {8'h00, m_plen};
      5'd5:    return m_active() ? m_mask : 32'h0;
      5'd6:    return {31'b0, m_active()};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_dout();
    return m_data | (m_active() ? m_mask : 32'h0);
  endfunction

  task automatic m_edge(input logic we, input logic [4:0] a, input logic [31:0] d);
    m_t++;
    if (we) begin
      case (a)
        5'd0: m_data = d;
        5'd1: m_data = m_data | d;
        5'd2: m_data = m_data & ~d;
        5'd3: m_data = m_data ^ d;
        5'd4: m_plen = d[23:0];
        5'd5: if (m_plen != 24'd0 && d != 32'd0) begin
                m_mask = (((m_t - 1) < m_exp) ? m_mask : 32'h0) | d;
                m_exp  = m_t + int'(m_plen);
              end
        default: ;
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r, d;
    logic [4:0]  a;

    vecs[0] = '{1'b0, 5'd0, 32'h0,         32'h0000_00A5, 5'd6, 32'h0};
    vecs[1] = '{1'b1, 5'd0, 32'h0000_F00F, 32'h0000_F00F, 5'd0, 32'h0000_F00F};
    vecs[2] = '{1'b1, 5'd1, 32'h0000_0F00, 32'h0000_FF0F, 5'd1, 32'h0};
    vecs[3] = '{1'b1, 5'd2, 32'h0000_000F, 32'h0000_FF00, 5'd2, 32'h0};
    vecs[4] = '{1'b1, 5'd3, 32'h0000_FFFF, 32'h0000_00FF, 5'd3, 32'h0};
    vecs[5] = '{1'b1, 5'd9, 32'hFFFF_FFFF, 32'h0000_00FF, 5'd9, 32'h0};
    vecs[6] = '{1'b1, 5'd6, 32'h0000_0001, 32'h0000_00FF, 5'd6, 32'h0};
    vecs[7] = '{1'b1, 5'd4, 32'hFF00_0005, 32'h0000_00FF, 5'd4, 32'h0000_0005};
    vecs[8] = '{1'b1, 5'd0, 32'h0,         32'h0,         5'd0, 32'h0};

    reset_n = 1'b0; cs = 1'b0; write = 1'b0; read = 1'b0;
    addr = 5'd0; write_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dout", 0, dout, RSTV);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);

    // Register map basics
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].we) bus_write(vecs[i].a, vecs[i].d);
      else idle(1);
      chk("vec_dout", i, dout, vecs[i].exp_dout);
      rd_chk("vec_rd", i, vecs[i].ra, vecs[i].exp_rd);
    end

    // Five-cycle pulse on bits 1:0 (PLEN is 5, DATA is 0)
    bus_write(5'd5, 32'h3);
    for (int i = 0; i < 5; i++) begin
      chk("p5_dout", i, dout, 32'h3);
      rd_chk("p5_busy", i, 5'd6, 32'h1);
      rd_chk("p5_pmask", i, 5'd5, 32'h3);
      idle(1);
    end
    chk("p5_end_dout", 0, dout, 32'h0);
    rd_chk("p5_end_busy", 0, 5'd6, 32'h0);
    rd_chk("p5_end_pmask", 0, 5'd5, 32'h0);

    // Retrigger exactly on the last count: no gap on bit 0
    bus_write(5'd4, 32'd4);
    bus_write(5'd5, 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("rt_first", i, dout, 32'h1);
      if (i < 3) idle(1);
    end
    bus_write(5'd5, 32'h2);
    for (int i = 0; i < 4; i++) begin
      chk("rt_both", i, dout, 32'h3);
      idle(1);
    end
    chk("rt_drop", 0, dout, 32'h0);

    // Zero length pulse is ignored; CLR during a pulse does not cut it short
    bus_write(5'd4, 32'd0);
    bus_write(5'd5, 32'hFF);
    chk("z_dout", 0, dout, 32'h0);
    rd_chk("z_busy", 0, 5'd6, 32'h0);
    idle(1);
    chk("z_dout", 1, dout, 32'h0);
    bus_write(5'd1, 32'h1);
    bus_write(5'd4, 32'd3);
    bus_write(5'd5, 32'h1);
    bus_write(5'd2, 32'h1);
    chk("clr_hold", 0, dout, 32'h1);
    idle(1);
    chk("clr_hold", 1, dout, 32'h1);
    idle(1);
    chk("clr_drop", 0, dout, 32'h0);
    rd_chk("clr_data", 0, 5'd0, 32'h0);

    // Asynchronous reset mid-pulse
    bus_write(5'd4, 32'd100);
    bus_write(5'd5, 32'h80);
    chk("ar_pulse", 0, dout, 32'h80);
    idle(3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_dout", 0, dout, RSTV);
    rd_chk("ar_busy", 0, 5'd6, 32'h0);
    rd_chk("ar_plen", 0, 5'd4, 32'h0);
    rd_chk("ar_pmask", 0, 5'd5, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    m_data = RSTV; m_mask = 32'h0; m_plen = 24'd0; m_t = 0; m_exp = 0;

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      cs = r[0] | r[1];
      write = r[2];
      read = r[3];
      a = (r[7:4] == 4'hF) ? 5'($urandom_range(7, 31)) : 5'($urandom_range(0, 7));
      case (a)
        5'd4:    d = ($urandom & 32'hFF00_0000) | 32'($urandom_range(0, 6));
        5'd5:    d = r[8] ? 32'h0 : ($urandom & 32'h0000_01FF);
        default: d = $urandom & $urandom & $urandom;
      endcase
      addr = a;
      write_data = d;
      #1;
      chk("rand_rd", i, read_data, m_read(a));
      @(posedge clk);
      #1;
      m_edge(cs & write, a, d);
      chk("rand_dout", i, dout, m_dout());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_gpo_pulse.md
# mmio_gpo_pulse

Parametrised general-purpose output slot for the MMIO bus, successor to the plain GPO slot. It drives `W` output bits and supports atomic set/clear/toggle writes so firmware can change individual bits without a read-modify-write. A hardware one-shot pulse generator can assert any subset of bits for a programmed number of clock cycles. All registers are readable back, and the block sits in one MMIO slot of the MCS I/O subsystem.

## Interface

Parameters:
- `W`, default 32: number of output bits, 1..32.
- `CNT_W`, default 24: width of the pulse length and pulse counter, 1..32.
- `RST_VAL`, default 0: `W`-bit reset value of the static data register.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `cs`  in  1  slot select.
- `write`  in  1  write strobe. A write occurs on a cycle with `cs & write`.
- `read`  in  1  read strobe. It has no side effects and is ignored internally.
- `addr`  in  5  word register index.
- `write_data`  in  32  write data.
- `read_data`  out  32  readback, combinational from `addr`.
- `dout`  out  W  external outputs.

## Operation

Register map (`addr`), accessed with `cs & write`:
- 0 DATA: write sets `data_reg <= write_data[W-1:0]`. Read returns `data_reg`.
- 1 SET: write sets `data_reg <= data_reg | wd`. Read returns 0.
- 2 CLR: write sets `data_reg <= data_reg & ~wd`. Read returns 0.
- 3 TOG: write sets `data_reg <= data_reg ^ wd`. Read returns 0.
- 4 PLEN: write sets `plen_reg <= write_data[CNT_W-1:0]`. Read returns `plen_reg`.
- 5 PULSE: write starts a one-shot on the bits set in `wd`. Read returns `pmask_reg`.
- 6 STATUS: writes are ignored. Read returns `{31'b0, busy}`, where `busy = (cnt_reg != 0)`.
- 7..31: unmapped. Writes are ignored and reads return 0.

Data rules:
- `wd = write_data[W-1:0]`.
- Write bits above `W` (or above `CNT_W` for PLEN) are ignored.
- Read bits above the register width return 0.

Output:
- `dout = data_reg | pmask_reg`.
- `dout` is built from registers only; there is no combinational path from the bus to `dout`.

Pulse generator: registers `pmask_reg` (`W` bits) and `cnt_reg` (`CNT_W` bits). States are IDLE (`cnt_reg == 0`) and ACTIVE (`cnt_reg != 0`).
- PULSE write with `plen_reg == 0` or `wd == 0`: no effect.
- PULSE write otherwise:
  - `pmask_reg <= pmask_reg | wd`.
  - `cnt_reg <= plen_reg`, which restarts the countdown for all pulsing bits.
- ACTIVE with no PULSE write:
  - if `cnt_reg > 1`, `cnt_reg` decrements;
  - if `cnt_reg == 1`, then `cnt_reg <= 0` and `pmask_reg <= 0`, returning to IDLE.
- A PULSE write in the cycle where `cnt_reg == 1`: the write wins. The counter reloads and the mask keeps the OR'd bits, so there is no glitch low on bits already pulsing.
- A PLEN write while ACTIVE does not affect the running countdown. It only applies to the next PULSE write.
- DATA/SET/CLR/TOG writes while ACTIVE change `data_reg` only. A pulsing bit stays high on `dout` until expiry even if cleared in `data_reg`.

Reset values:
- `data_reg = RST_VAL`.
- `plen_reg = 0`, `pmask_reg = 0`, `cnt_reg = 0`.
- Therefore `dout = RST_VAL[W-1:0]`.
- Reset asserted mid-pulse immediately clears the pulse, asynchronously.

## Timing

- A write accepted at rising edge k updates the registers, and `dout` reflects it from edge k onward (visible in the cycle after the write cycle). Latency is 1 clock.
- Pulse length: a PULSE write at edge k with `plen_reg = N` holds the selected bits high for exactly N clk cycles, edges k..k+N-1. They drop at edge k+N.
- `busy` is high over the same N cycles.
- `read_data` is valid in the same cycle as `addr`. It is independent of `cs`/`read`; the bus muxes by slot.
- Back-to-back writes on consecutive cycles are all accepted. There is no stall or handshake.

## Test plan

1. Reset with `RST_VAL = 32'hA5` -> `dout = 32'hA5`, STATUS reads 0. Then DATA write `32'h0000_F00F` -> `dout = 32'hF00F` one cycle later, DATA reads `32'hF00F`.
2. From DATA `= 32'hF00F`: SET `32'h0F00` -> `32'hFF0F`, then CLR `32'h000F` -> `32'hFF00`, then TOG `32'hFFFF` -> `32'h00FF`. Each result is visible one cycle after its write.
3. PLEN = 5, DATA = 0, PULSE `32'h3` -> `dout[1:0] = 2'b11` for exactly 5 cycles, then 0. STATUS reads 1 during the pulse and 0 after. PULSE reads `32'h3` during the pulse.
4. PLEN = 4, PULSE `32'h1`, then PULSE `32'h2` in the cycle where the counter equals 1 -> bit 0 stays high with no gap. Both bits drop together 4 cycles after the second write.
5. PLEN = 0, PULSE `32'hFF` -> `dout` is unchanged and STATUS stays 0. Separately, PLEN = 3, PULSE `32'h1`, then CLR `32'h1` mid-pulse -> bit 0 stays high until expiry.
6. PLEN = 100, PULSE `32'h80`, assert `reset_n` low mid-pulse -> `dout = RST_VAL` immediately, with no clock edge needed. Also check that writes to addr 9 are ignored and reads of addr 9 return 0.
